spr_arb: RTL and testbench
==========================

# spr_arb

Three-way access arbiter that shares the single external port of the dual-port sprite/video RAM between the video fetcher, the ROM/tape loader and the CPU. It sits directly in front of the RAM's second port and drives its clock-enable, write-enable, address and write data, then routes read data back to the granted requester. Each requester uses a req/ack handshake. The block guarantees bounded CPU latency despite video having top priority.

## Interface
- `AW`, 14: RAM address width (RAM depth 2**AW bytes).
- `clock`  in  1  system clock; RAM shares it.
- `reset`  in  1  synchronous, active-high.
- `vid_req`  in  1  video fetch request (read only); held until `vid_ack`.
- `vid_a`  in  AW  video address.
- `vid_q`  out  8  video read data.
- `vid_ack`  out  1  one-cycle completion pulse.
- `ld_req`  in  1  loader request (write only); held until `ld_ack`.
- `ld_a`  in  AW  loader address.
- `ld_d`  in  8  loader write data.
- `ld_ack`  out  1  one-cycle completion pulse.
- `cpu_req`  in  1  CPU request; held until `cpu_ack`.
- `cpu_wr`  in  1  1 = write, 0 = read.
- `cpu_a`  in  AW  CPU address.
- `cpu_d`  in  8  CPU write data.
- `cpu_q`  out  8  CPU read data.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `ram_ce`  out  1  RAM port enable.
- `ram_we`  out  1  RAM write enable, **active-low** (0 = write, 1 = read).
- `ram_a`  out  AW  RAM address.
- `ram_di`  out  8  RAM write data.
- `ram_do`  in  8  RAM read data, valid the cycle after an enabled read.

## Operation
- States:
  - IDLE: arbitrate among pending requests.
  - ACCESS: `ram_ce`=1 for exactly one cycle.
  - DATA: `ram_do` is valid; capture it.
  - Transitions: IDLE→ACCESS on any unmasked request. ACCESS→DATA always. DATA→IDLE always.
- Priority in IDLE:
  - CPU wins if `cpu_skip`=3.
  - Otherwise video > loader > CPU.
- `cpu_skip` is a 2-bit saturating counter:
  - +1 on each grant to another requester while `cpu_req` is high.
  - Cleared on a CPU grant.
  - Cleared on reset.
- Request latching:
  - On grant, address, data and direction are registered into `ram_a`, `ram_di` and `ram_we`.
  - Requester inputs are don't-care after the grant cycle.
- Read completion: in DATA, `ram_do` is registered into `vid_q` or `cpu_q`. The matching ack is registered high in the same edge.
- Write completion: the ack asserts in the same cycle as for a read. `*_q` is unchanged.
- Ack masking: in the IDLE cycle where a requester's ack is high, that requester's req is masked, because it is still held from before the ack.
- Idle outputs: `ram_we`=1 and `ram_ce`=0 whenever the state is not ACCESS. `ram_a` and `ram_di` hold their last values.
- Reset values: `ram_ce`=0, `ram_we`=1, `ram_a`=0, `ram_di`=0, `vid_q`=0, `cpu_q`=0, all acks 0, state IDLE, `cpu_skip`=0.
- Reset mid-operation: any in-flight access is abandoned and no ack is issued. If it was a write already in ACCESS, the RAM write completes; this is acceptable.

## Timing
- Request seen in IDLE at cycle N:
  - `ram_ce`=1 in N+1.
  - `ram_do` valid in N+2.
  - `*_q` and `*_ack` valid in N+3.
- The ack pulse is exactly 1 cycle.
- Peak throughput: one access per 3 cycles; a new grant is possible in N+3.
- Worst-case CPU latency with all requesters saturated: 3 foreign grants + own = 12 cycles from req to ack.
- Simultaneous requests are resolved in a single IDLE cycle. No request is lost.

## Structure
- Shared package `spr_pkg` holds:
  - State encoding (IDLE, ACCESS, DATA).
  - Grant encoding (GNT_NONE, GNT_VID, GNT_LD, GNT_CPU).
  - `SKIP_MAX`=3.
- One natural sub-module: `spr_prio`, a combinational priority encoder.
  - Inputs: masked reqs and the skip-saturated flag.
  - Output: grant code.
- The RAM itself is instantiated outside this block.

## Test plan
- Single CPU read: preload RAM[0x0123]=0x5A, pulse `cpu_req` with `cpu_wr`=0 and `cpu_a`=0x0123 at cycle N.
  - Require `ram_ce` at N+1 with `ram_we`=1.
  - Require `cpu_ack` and `cpu_q`=0x5A at N+3, `ram_ce`=0 elsewhere.
- Loader write then CPU readback: `ld_a`=0x3FFF, `ld_d`=0xC3.
  - Require `ram_we`=0 in the ACCESS cycle and `ld_ack` at N+3.
  - A subsequent CPU read of 0x3FFF returns 0xC3.
- Simultaneous requests: all three reqs rise at the same cycle.
  - Grant order is vid, ld, cpu.
  - Acks arrive at N+3, N+6 and N+9, each exactly one cycle wide.
- Starvation guard: hold `vid_req` and `ld_req` continuously with `cpu_req` high.
  - The CPU is granted after exactly 3 foreign grants.
  - `cpu_skip` then returns to 0 and the pattern repeats.
- Reset in ACCESS: assert `reset` during the `ram_ce` cycle of a CPU read.
  - Next cycle: `ram_ce`=0, `ram_we`=1, `cpu_q`=0, no `cpu_ack`, state IDLE.
  - A re-issued request completes normally.
- Ack masking: the requester drops req one cycle after its ack.
  - No duplicate access occurs; `ram_ce` pulses exactly once per transaction.

Source files
------------

// File: rtl/spr_pkg.sv
// Shared encodings for the sprite/video RAM port arbiter.
// Holds the FSM states, grant codes and the CPU anti-starvation limit.
package spr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DATA   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_VID  = 2'd1,
        GNT_LD   = 2'd2,
        GNT_CPU  = 2'd3
    } gnt_t;

    localparam logic [1:0] SKIP_MAX = 2'd3;

endpackage

// File: rtl/spr_arb_prio.sv
// spr_prio: combinational priority encoder for the RAM port arbiter.
// Video > loader > CPU, except that a saturated skip counter lets the CPU jump the queue.
module spr_prio
    import spr_pkg::*;
(
    input  logic       i_vid_req,
    input  logic       i_ld_req,
    input  logic       i_cpu_req,
    input  logic       i_skip_sat,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = GNT_NONE;
        if (i_cpu_req && i_skip_sat) begin
            o_gnt = GNT_CPU;
        end else if (i_vid_req) begin
            o_gnt = GNT_VID;
        end else if (i_ld_req) begin
            o_gnt = GNT_LD;
        end else if (i_cpu_req) begin
            o_gnt = GNT_CPU;
        end
    end

endmodule

// File: rtl/spr_arb.sv
// spr_arb: shares the external sprite/video RAM port between video, loader and CPU.
// Every access takes IDLE -> ACCESS -> DATA; a skip counter bounds CPU latency.
module spr_arb
    import spr_pkg::*;
#(
    parameter int AW = 14
) (
    input  logic          clock,
    input  logic          reset,
    // Handshake: a requester raises *_req with its operands valid and holds them until
    // the grant edge; it keeps *_req high until it sees its one-cycle *_ack and may drop
    // it the cycle after. A req that is high while its own ack is high is never a new request.
    input  logic          vid_req,
    input  logic [AW-1:0] vid_a,
    output logic [7:0]    vid_q,
    output logic          vid_ack,
    input  logic          ld_req,
    input  logic [AW-1:0] ld_a,
    input  logic [7:0]    ld_d,
    output logic          ld_ack,
    input  logic          cpu_req,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_a,
    input  logic [7:0]    cpu_d,
    output logic [7:0]    cpu_q,
    output logic          cpu_ack,
    output logic          ram_ce,
    output logic          ram_we,
    output logic [AW-1:0] ram_a,
    output logic [7:0]    ram_di,
    input  logic [7:0]    ram_do,
    output logic [1:0]    dbg_state,
    output logic [1:0]    dbg_cpu_skip
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_gnt;
    logic       r_cpu_rd;
    logic [1:0] r_cpu_skip;
    logic       w_vid_m;
    logic       w_ld_m;
    logic       w_cpu_m;
    logic       w_skip_sat;
    logic       w_start;
    logic [1:0] w_gnt;

    assign w_vid_m    = vid_req & ~vid_ack;
    assign w_ld_m     = ld_req  & ~ld_ack;
    assign w_cpu_m    = cpu_req & ~cpu_ack;
    assign w_skip_sat = (r_cpu_skip == SKIP_MAX);
    assign w_start    = (r_state == IDLE) && (w_gnt != GNT_NONE);

    spr_prio u_prio (
        .i_vid_req  (w_vid_m),
        .i_ld_req   (w_ld_m),
        .i_cpu_req  (w_cpu_m),
        .i_skip_sat (w_skip_sat),
        .o_gnt      (w_gnt)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_nxt = ACCESS;
            ACCESS:  w_state_nxt = DATA;
            DATA:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operands are captured on the grant edge so requesters may change them afterwards.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_gnt      <= GNT_NONE;
            r_cpu_rd   <= 1'b0;
            r_cpu_skip <= '0;
            ram_ce     <= 1'b0;
            ram_we     <= 1'b1;
            ram_a      <= '0;
            ram_di     <= '0;
            vid_q      <= '0;
            cpu_q      <= '0;
            vid_ack    <= 1'b0;
            ld_ack     <= 1'b0;
            cpu_ack    <= 1'b0;
        end else begin
            ram_ce  <= 1'b0;
            ram_we  <= 1'b1;
            vid_ack <= 1'b0;
            ld_ack  <= 1'b0;
            cpu_ack <= 1'b0;
            if (w_start) begin
                r_gnt  <= w_gnt;
                ram_ce <= 1'b1;
                case (w_gnt)
                    GNT_VID: ram_a <= vid_a;
                    GNT_LD: begin
                        ram_a  <= ld_a;
                        ram_di <= ld_d;
                        ram_we <= 1'b0;
                    end
                    GNT_CPU: begin
                        ram_a    <= cpu_a;
                        ram_di   <= cpu_d;
                        ram_we   <= ~cpu_wr;
                        r_cpu_rd <= ~cpu_wr;
                    end
                    default: ;
                endcase
                // Any CPU req level counts, including the stale one held during its ack.
                if (w_gnt == GNT_CPU) begin
                    r_cpu_skip <= '0;
                end else if (cpu_req && !w_skip_sat) begin
                    r_cpu_skip <= r_cpu_skip + 2'd1;
                end
            end
            if (r_state == DATA) begin
                case (r_gnt)
                    GNT_VID: begin
                        vid_q   <= ram_do;
                        vid_ack <= 1'b1;
                    end
                    GNT_LD:  ld_ack <= 1'b1;
                    GNT_CPU: begin
                        if (r_cpu_rd) cpu_q <= ram_do;
                        cpu_ack <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign dbg_state    = r_state;
    assign dbg_cpu_skip = r_cpu_skip;

endmodule

// File: tb/tb_spr_arb.sv
// Self-checking bench for spr_arb: directed scenarios plus randomized rounds checked
// against a grant-order model and a reference memory image.
module tb_spr_arb;
    import spr_pkg::*;

    localparam int AW = 14;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          vid_req = 1'b0, ld_req = 1'b0, cpu_req = 1'b0, cpu_wr = 1'b0;
    logic [AW-1:0] vid_a = '0, ld_a = '0, cpu_a = '0;
    logic [7:0]    ld_d = '0, cpu_d = '0;
    logic [7:0]    vid_q, cpu_q, ram_di;
    logic [7:0]    ram_do = '0;
    logic          vid_ack, ld_ack, cpu_ack, ram_ce, ram_we;
    logic [AW-1:0] ram_a;
    logic [1:0]    dbg_state, dbg_cpu_skip;

    logic [7:0] mem     [0:(1<<AW)-1];
    logic [7:0] ref_mem [0:(1<<AW)-1];
    logic       bd_copy = 1'b0;
    int cyc = 0, ce_count = 0, vid_ack_n = 0, ld_ack_n = 0, cpu_ack_n = 0;
    int n_checks = 0, n_fail = 0;
    int model_skip = 0;
    logic [7:0] exp_q[$];

    spr_arb #(.AW(AW)) dut (
        .clock(clock), .reset(reset),
        .vid_req(vid_req), .vid_a(vid_a), .vid_q(vid_q), .vid_ack(vid_ack),
        .ld_req(ld_req), .ld_a(ld_a), .ld_d(ld_d), .ld_ack(ld_ack),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_a(cpu_a), .cpu_d(cpu_d),
        .cpu_q(cpu_q), .cpu_ack(cpu_ack),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di), .ram_do(ram_do),
        .dbg_state(dbg_state), .dbg_cpu_skip(dbg_cpu_skip)
    );

    // Clock/reset block, synchronous RAM model and event counters
    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (vid_ack) vid_ack_n <= vid_ack_n + 1;
        if (ld_ack)  ld_ack_n  <= ld_ack_n + 1;
        if (cpu_ack) cpu_ack_n <= cpu_ack_n + 1;
        if (bd_copy) begin
            for (int i = 0; i < (1<<AW); i++) mem[i] <= ref_mem[i];
        end else if (ram_ce) begin
            ce_count <= ce_count + 1;
            if (!ram_we) mem[ram_a] <= ram_di;
            else         ram_do     <= mem[ram_a];
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish, cyc=%0d required<100000", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Driver tasks: raise req, wait (bounded) for ack, hold req through the ack cycle
    task automatic drive_vid(input logic [AW-1:0] a, output logic [7:0] q, output int ack_cyc);
        vid_req = 1'b1; vid_a = a; ack_cyc = -1; q = '0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (vid_ack) begin ack_cyc = cyc; q = vid_q; break; end
        end
        n_checks++;
        if (ack_cyc < 0) begin n_fail++; $display("FAIL vid_timeout ack=none required=ack within 40 cycles a=%h", a); end
        else tick();
        vid_req = 1'b0;
    endtask

    task automatic drive_ld(input logic [AW-1:0] a, input logic [7:0] d, output int ack_cyc);
        ld_req = 1'b1; ld_a = a; ld_d = d; ack_cyc = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ld_ack) begin ack_cyc = cyc; break; end
        end
        n_checks++;
        if (ack_cyc < 0) begin n_fail++; $display("FAIL ld_timeout ack=none required=ack within 40 cycles a=%h", a); end
        else tick();
        ld_req = 1'b0;
    endtask

    task automatic drive_cpu(input logic wr, input logic [AW-1:0] a, input logic [7:0] d,
                             output logic [7:0] q, output int ack_cyc);
        cpu_req = 1'b1; cpu_wr = wr; cpu_a = a; cpu_d = d; ack_cyc = -1; q = '0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (cpu_ack) begin ack_cyc = cyc; q = cpu_q; break; end
        end
        n_checks++;
        if (ack_cyc < 0) begin n_fail++; $display("FAIL cpu_timeout ack=none required=ack within 40 cycles a=%h", a); end
        else tick();
        cpu_req = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < (1<<AW); i++) ref_mem[i] = 8'($urandom);
        ref_mem[14'h0123] = 8'h5A;
        reset = 1'b1; bd_copy = 1'b1;
        tick(); tick();
        bd_copy = 1'b0;
        tick();
        n_checks++; if (ram_ce !== 1'b0)     begin n_fail++; $display("FAIL rst_ram_ce got=%b exp=0", ram_ce); end
        n_checks++; if (ram_we !== 1'b1)     begin n_fail++; $display("FAIL rst_ram_we got=%b exp=1", ram_we); end
        n_checks++; if (ram_a !== '0)        begin n_fail++; $display("FAIL rst_ram_a got=%h exp=0", ram_a); end
        n_checks++; if (ram_di !== 8'h00)    begin n_fail++; $display("FAIL rst_ram_di got=%h exp=0", ram_di); end
        n_checks++; if (vid_q !== 8'h00)     begin n_fail++; $display("FAIL rst_vid_q got=%h exp=0", vid_q); end
        n_checks++; if (cpu_q !== 8'h00)     begin n_fail++; $display("FAIL rst_cpu_q got=%h exp=0", cpu_q); end
        n_checks++; if ({vid_ack, ld_ack, cpu_ack} !== 3'b000) begin n_fail++; $display("FAIL rst_acks got=%b exp=000", {vid_ack, ld_ack, cpu_ack}); end
        n_checks++; if (dbg_state !== IDLE)  begin n_fail++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state, IDLE); end
        n_checks++; if (dbg_cpu_skip !== 2'd0) begin n_fail++; $display("FAIL rst_skip got=%0d exp=0", dbg_cpu_skip); end
        reset = 1'b0;
        tick();
        n_checks++; if (ram_ce !== 1'b0)     begin n_fail++; $display("FAIL idle_ram_ce got=%b exp=0", ram_ce); end
        model_skip = 0;
    endtask

    // Single CPU read with cycle-exact checks; req is still high during the ack cycle
    task automatic test_cpu_read();
        int ce0;
        ce0 = ce_count;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_a = 14'h0123; cpu_d = 8'($urandom);
        tick();
        n_checks++; if (ram_ce !== 1'b1)       begin n_fail++; $display("FAIL rd_ce_n1 got=%b exp=1", ram_ce); end
        n_checks++; if (ram_we !== 1'b1)       begin n_fail++; $display("FAIL rd_we_n1 got=%b exp=1", ram_we); end
        n_checks++; if (ram_a !== 14'h0123)    begin n_fail++; $display("FAIL rd_a_n1 got=%h exp=0123", ram_a); end
        cpu_a = AW'($urandom);
        tick();
        n_checks++; if (ram_ce !== 1'b0 || cpu_ack !== 1'b0) begin n_fail++; $display("FAIL rd_n2 ce=%b ack=%b exp=0,0", ram_ce, cpu_ack); end
        n_checks++; if (dbg_state !== DATA)    begin n_fail++; $display("FAIL rd_state_n2 got=%0d exp=%0d", dbg_state, DATA); end
        tick();
        n_checks++; if (cpu_ack !== 1'b1)      begin n_fail++; $display("FAIL rd_ack_n3 got=%b exp=1", cpu_ack); end
        n_checks++; if (cpu_q !== 8'h5A)       begin n_fail++; $display("FAIL rd_q_n3 got=%h exp=5a", cpu_q); end
        tick();
        cpu_req = 1'b0;
        n_checks++; if (cpu_ack !== 1'b0 || ram_ce !== 1'b0) begin n_fail++; $display("FAIL rd_mask_n4 ack=%b ce=%b exp=0,0", cpu_ack, ram_ce); end
        tick(); tick(); tick();
        n_checks++; if (ce_count - ce0 !== 1)  begin n_fail++; $display("FAIL rd_ce_pulses got=%0d exp=1", ce_count - ce0); end
    endtask

    task automatic test_ld_write();
        logic [7:0] q;
        int ac, n0;
        ld_req = 1'b1; ld_a = 14'h3FFF; ld_d = 8'hC3;
        tick();
        n_checks++; if (ram_ce !== 1'b1 || ram_we !== 1'b0) begin n_fail++; $display("FAIL wr_n1 ce=%b we=%b exp=1,0", ram_ce, ram_we); end
        n_checks++; if (ram_a !== 14'h3FFF || ram_di !== 8'hC3) begin n_fail++; $display("FAIL wr_n1_op a=%h di=%h exp=3fff,c3", ram_a, ram_di); end
        ld_d = 8'h00;
        tick();
        n_checks++; if (ram_we !== 1'b1)       begin n_fail++; $display("FAIL wr_we_n2 got=%b exp=1", ram_we); end
        tick();
        n_checks++; if (ld_ack !== 1'b1)       begin n_fail++; $display("FAIL wr_ack_n3 got=%b exp=1", ld_ack); end
        tick();
        ld_req = 1'b0;
        ref_mem[14'h3FFF] = 8'hC3;
        n0 = cyc;
        drive_cpu(1'b0, 14'h3FFF, 8'h00, q, ac);
        n_checks++; if (q !== ref_mem[14'h3FFF]) begin n_fail++; $display("FAIL wr_readback got=%h exp=%h", q, ref_mem[14'h3FFF]); end
        n_checks++; if (ac - n0 !== 3)         begin n_fail++; $display("FAIL wr_readback_lat got=%0d exp=3", ac - n0); end
    endtask

    task automatic test_simultaneous();
        logic [7:0] qv, qc;
        int av, al, ac, n0, vn, ln, cn;
        vn = vid_ack_n; ln = ld_ack_n; cn = cpu_ack_n;
        n0 = cyc;
        fork
            drive_vid(14'h0040, qv, av);
            drive_ld(14'h2005, 8'hA7, al);
            drive_cpu(1'b0, 14'h1003, 8'h00, qc, ac);
        join
        n_checks++; if (av - n0 !== 3) begin n_fail++; $display("FAIL sim_vid_lat got=%0d exp=3", av - n0); end
        n_checks++; if (al - n0 !== 6) begin n_fail++; $display("FAIL sim_ld_lat got=%0d exp=6", al - n0); end
        n_checks++; if (ac - n0 !== 9) begin n_fail++; $display("FAIL sim_cpu_lat got=%0d exp=9", ac - n0); end
        n_checks++; if (qv !== ref_mem[14'h0040]) begin n_fail++; $display("FAIL sim_vid_q got=%h exp=%h", qv, ref_mem[14'h0040]); end
        n_checks++; if (qc !== ref_mem[14'h1003]) begin n_fail++; $display("FAIL sim_cpu_q got=%h exp=%h", qc, ref_mem[14'h1003]); end
        n_checks++; if (vid_ack_n - vn !== 1 || ld_ack_n - ln !== 1 || cpu_ack_n - cn !== 1) begin
            n_fail++; $display("FAIL sim_ack_width vid=%0d ld=%0d cpu=%0d exp=1,1,1", vid_ack_n - vn, ld_ack_n - ln, cpu_ack_n - cn);
        end
        ref_mem[14'h2005] = 8'hA7;
    endtask

    // Video and loader saturate the port; the CPU must win every fourth grant
    task automatic test_starvation();
        bit stop;
        int n0, c1, c2;
        logic [7:0] qc1, qc2;
        stop = 1'b0;
        n0 = cyc;
        fork
            while (!stop) begin
                logic [AW-1:0] a;
                logic [7:0] q;
                int ac;
                a = AW'($urandom_range(0, 255));
                drive_vid(a, q, ac);
                n_checks++; if (q !== ref_mem[a]) begin n_fail++; $display("FAIL stv_vid_q a=%h got=%h exp=%h", a, q, ref_mem[a]); end
            end
            while (!stop) begin
                logic [AW-1:0] a;
                logic [7:0] d;
                int ac;
                a = AW'(32'h3000 + $urandom_range(0, 255));
                d = 8'($urandom);
                drive_ld(a, d, ac);
                ref_mem[a] = d;
            end
            begin
                drive_cpu(1'b0, 14'h0123, 8'h00, qc1, c1);
                drive_cpu(1'b0, 14'h0123, 8'h00, qc2, c2);
                stop = 1'b1;
            end
            begin
                repeat (9) tick();
                n_checks++; if (dbg_cpu_skip !== 2'd3) begin n_fail++; $display("FAIL stv_skip_sat1 got=%0d exp=3", dbg_cpu_skip); end
                tick();
                n_checks++; if (dbg_cpu_skip !== 2'd0 || ram_a !== 14'h0123) begin n_fail++; $display("FAIL stv_cpu_gnt1 skip=%0d a=%h exp=0,0123", dbg_cpu_skip, ram_a); end
                repeat (11) tick();
                n_checks++; if (dbg_cpu_skip !== 2'd3) begin n_fail++; $display("FAIL stv_skip_sat2 got=%0d exp=3", dbg_cpu_skip); end
                tick();
                n_checks++; if (dbg_cpu_skip !== 2'd0) begin n_fail++; $display("FAIL stv_skip_clr2 got=%0d exp=0", dbg_cpu_skip); end
            end
        join
        n_checks++; if (c1 - n0 !== 12) begin n_fail++; $display("FAIL stv_cpu_lat1 got=%0d exp=12", c1 - n0); end
        n_checks++; if (c2 - n0 !== 24) begin n_fail++; $display("FAIL stv_cpu_lat2 got=%0d exp=24", c2 - n0); end
        n_checks++; if (qc1 !== 8'h5A || qc2 !== 8'h5A) begin n_fail++; $display("FAIL stv_cpu_q got=%h,%h exp=5a,5a", qc1, qc2); end
    endtask

    task automatic test_reset_in_access();
        logic [7:0] q;
        int ac, n0;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_a = 14'h0123;
        tick();
        n_checks++; if (ram_ce !== 1'b1) begin n_fail++; $display("FAIL rsa_ce got=%b exp=1", ram_ce); end
        reset = 1'b1; cpu_req = 1'b0;
        tick();
        reset = 1'b0;
        n_checks++; if (ram_ce !== 1'b0 || ram_we !== 1'b1) begin n_fail++; $display("FAIL rsa_port ce=%b we=%b exp=0,1", ram_ce, ram_we); end
        n_checks++; if (cpu_q !== 8'h00 || cpu_ack !== 1'b0) begin n_fail++; $display("FAIL rsa_cpu q=%h ack=%b exp=00,0", cpu_q, cpu_ack); end
        n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL rsa_state got=%0d exp=%0d", dbg_state, IDLE); end
        tick();
        n_checks++; if (cpu_ack !== 1'b0 || ram_ce !== 1'b0) begin n_fail++; $display("FAIL rsa_no_ack ack=%b ce=%b exp=0,0", cpu_ack, ram_ce); end
        model_skip = 0;
        n0 = cyc;
        drive_cpu(1'b0, 14'h0123, 8'h00, q, ac);
        n_checks++; if (q !== 8'h5A || ac - n0 !== 3) begin n_fail++; $display("FAIL rsa_reissue q=%h lat=%0d exp=5a,3", q, ac - n0); end
    endtask

    // Random rounds: expected ack times from the priority/skip rules, data from ref_mem
    task automatic test_random();
        for (int r = 0; r < 40; r++) begin
            bit uv, ul, uc, cwr, pv, pl, pc, craw;
            logic [AW-1:0] va, la, ca;
            logic [7:0] ldv, cd, qv, qc, exp_c;
            int tv, tl, tc, av, al, ac, n0, skip;
            uv = 1'($urandom_range(0, 1)); ul = 1'($urandom_range(0, 1)); uc = 1'($urandom_range(0, 1));
            if (!(uv || ul || uc)) uc = 1'b1;
            la  = AW'(32'h2000 + $urandom_range(0, 15));
            va  = ul ? AW'($urandom_range(0, 4095)) : AW'(32'h2000 + $urandom_range(0, 15));
            ca  = AW'(32'h1000 + $urandom_range(0, 15));
            cwr = 1'($urandom_range(0, 1));
            cd  = 8'($urandom); ldv = 8'($urandom);
            if (uc && !cwr) exp_q.push_back(ref_mem[ca]);
            tv = -1; tl = -1; tc = -1; pv = uv; pl = ul; pc = uc; skip = model_skip;
            for (int t = 0; t <= 6; t += 3) begin
                craw = pc || (tc == t);
                if (pc && skip == 3) begin tc = t + 3; pc = 1'b0; skip = 0; end
                else if (pv) begin tv = t + 3; pv = 1'b0; if (craw && skip < 3) skip++; end
                else if (pl) begin tl = t + 3; pl = 1'b0; if (craw && skip < 3) skip++; end
                else if (pc) begin tc = t + 3; pc = 1'b0; skip = 0; end
            end
            model_skip = skip;
            n0 = cyc;
            fork
                if (uv) drive_vid(va, qv, av);
                if (ul) drive_ld(la, ldv, al);
                if (uc) drive_cpu(cwr, ca, cd, qc, ac);
            join
            if (uv) begin
                n_checks++; if (av - n0 !== tv) begin n_fail++; $display("FAIL rnd%0d_vid_lat got=%0d exp=%0d", r, av - n0, tv); end
                n_checks++; if (qv !== ref_mem[va]) begin n_fail++; $display("FAIL rnd%0d_vid_q a=%h got=%h exp=%h", r, va, qv, ref_mem[va]); end
            end
            if (ul) begin
                n_checks++; if (al - n0 !== tl) begin n_fail++; $display("FAIL rnd%0d_ld_lat got=%0d exp=%0d", r, al - n0, tl); end
                ref_mem[la] = ldv;
            end
            if (uc) begin
                n_checks++; if (ac - n0 !== tc) begin n_fail++; $display("FAIL rnd%0d_cpu_lat got=%0d exp=%0d", r, ac - n0, tc); end
                if (cwr) begin
                    ref_mem[ca] = cd;
                end else begin
                    exp_c = exp_q.pop_front();
                    n_checks++; if (qc !== exp_c) begin n_fail++; $display("FAIL rnd%0d_cpu_q a=%h got=%h exp=%h", r, ca, qc, exp_c); end
                end
            end
            n_checks++; if (dbg_cpu_skip !== 2'(model_skip)) begin n_fail++; $display("FAIL rnd%0d_skip got=%0d exp=%0d", r, dbg_cpu_skip, model_skip); end
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_ld_write();
        test_simultaneous();
        test_starvation();
        test_reset_in_access();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
